// File: rtl/md_unit_e.sv
// md_unit_e: execute-stage multi-cycle multiply/divide unit.
// Owns HI/LO, serves mfhi/mflo reads and requests a decode stall while an
// operation is in flight. Results are computed at the start edge and held
// in pending registers until the busy window elapses.
module md_unit_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mdOpE,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic        mdInstD,
    output logic        busyE,
    output logic        stallMdD,
    output logic [31:0] hiloOutE,
    output logic [31:0] hiE,
    output logic [31:0] loE
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        pendValid;
    logic        isStart;
    logic        isDiv;
    logic [63:0] startRes;

    // Signed 32x32 product, both operands sign-extended to 64 bits.
    function automatic logic [63:0] mulSigned(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        p  = sa * sb;
        return p;
    endfunction

    // Signed divide via magnitudes; quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    // Returns {remainder, quotient}.
    function automatic logic [63:0] divSigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] magA;
        logic [31:0] magB;
        logic [31:0] q;
        logic [31:0] r;
        magA = a[31] ? (32'd0 - a) : a;
        magB = b[31] ? (32'd0 - b) : b;
        q = 32'd0;
        r = 32'd0;
        if (magB != 32'd0) begin
            q = magA / magB;
            r = magA % magB;
        end
        if (a[31] ^ b[31]) q = 32'd0 - q;
        if (a[31])         r = 32'd0 - r;
        return {r, q};
    endfunction

    // Unsigned divide, {remainder, quotient}; zero divisor yields zero.
    function automatic logic [63:0] divUnsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    assign isStart  = (mdOpE >= OP_MULT) && (mdOpE <= OP_DIVU);
    assign isDiv    = (mdOpE == OP_DIV) || (mdOpE == OP_DIVU);
    assign stallMdD = mdInstD & (busyE | isStart);

    // Full 64-bit result of the op presented this cycle, {HI, LO}.
    always_comb begin
        startRes = 64'd0;
        case (mdOpE)
            OP_MULT:  startRes = mulSigned(rd1E, rd2E);
            OP_MULTU: startRes = {32'd0, rd1E} * {32'd0, rd2E};
            OP_DIV:   startRes = divSigned(rd1E, rd2E);
            OP_DIVU:  startRes = divUnsigned(rd1E, rd2E);
            default:  startRes = 64'd0;
        endcase
    end

    // Read port for mfhi/mflo; returns the current architectural value.
    always_comb begin
        hiloOutE = 32'd0;
        if (mdOpE == OP_MFHI)      hiloOutE = hiE;
        else if (mdOpE == OP_MFLO) hiloOutE = loE;
    end

    // Control FSM: start/latch, count down the busy window, commit on 1->0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busyE     <= 1'b0;
            count     <= 4'd0;
            pendHi    <= 32'd0;
            pendLo    <= 32'd0;
            pendValid <= 1'b0;
            hiE       <= 32'd0;
            loE       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (isStart) begin
                        pendHi    <= startRes[63:32];
                        pendLo    <= startRes[31:0];
                        pendValid <= !(isDiv && (rd2E == 32'd0));
                        count     <= isDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        busyE     <= 1'b1;
                        state     <= BUSY;
                    end else if (mdOpE == OP_MTHI) begin
                        hiE <= rd1E;
                    end else if (mdOpE == OP_MTLO) begin
                        loE <= rd1E;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        if (pendValid) begin
                            hiE <= pendHi;
                            loE <= pendLo;
                        end
                        busyE <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_e.sv
// tb_md_unit_e: scoreboard bench for the execute-stage multiply/divide unit.
module tb_md_unit_e;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mdOpE;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic        mdInstD;
    logic        busyE;
    logic        stallMdD;
    logic [31:0] hiloOutE;
    logic [31:0] hiE;
    logic [31:0] loE;

    int nChecks = 0;
    int nPass   = 0;

    logic [63:0] expQ[$];
    logic [31:0] mHi;
    logic [31:0] mLo;

    md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .mdOpE(mdOpE), .rd1E(rd1E), .rd2E(rd2E),
        .mdInstD(mdInstD), .busyE(busyE), .stallMdD(stallMdD),
        .hiloOutE(hiloOutE), .hiE(hiE), .loE(loE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard logic must never present a start or mthi/mtlo while busy.
    always @(posedge clk) begin
        if (rst_n && busyE)
            assert (!((mdOpE >= 4'd1 && mdOpE <= 4'd4) || mdOpE == 4'd7 || mdOpE == 4'd8))
                else $error("MD op issued while busy");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference model, independent 64-bit arithmetic. Returns {HI, LO}.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 32'd0) return {mHi, mLo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {mHi, mLo};
                return {a % b, a / b};
            end
            default: return {mHi, mLo};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, check the busy window, stall and the committed result.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit inst);
        int n;
        logic [63:0] e;
        int expCycles;
        expCycles = (op >= 4'd3) ? 10 : 5;
        mdOpE   = op;
        rd1E    = a;
        rd2E    = b;
        mdInstD = inst;
        expQ.push_back(exp);
        #1;
        if (inst) check({tag, " stall@start"}, 64'(stallMdD), 64'd1);
        tick();
        // Operands change and an mfhi is issued mid-flight; neither may matter.
        mdOpE = 4'd5;
        rd1E  = $urandom;
        rd2E  = $urandom;
        #1;
        check({tag, " mfhi old"}, 64'(hiloOutE), 64'(mHi));
        n = 0;
        while (busyE && n < 40) begin
            if (inst && !stallMdD) check({tag, " stall busy"}, 64'(stallMdD), 64'd1);
            tick();
            n++;
        end
        check({tag, " cycles"}, 64'(n), 64'(expCycles));
        if (inst) check({tag, " stall fall"}, 64'(stallMdD), 64'd0);
        e = expQ.pop_front();
        check({tag, " hilo"}, {hiE, loE}, e);
        mHi = e[63:32];
        mLo = e[31:0];
        mdOpE   = 4'd0;
        mdInstD = 1'b0;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; mdOpE = 4'd0; rd1E = 32'd0; rd2E = 32'd0; mdInstD = 1'b0;
        mHi = 32'd0; mLo = 32'd0;
        #1;
        check("rst busy",  64'(busyE), 64'd0);
        check("rst hi",    64'(hiE),   64'd0);
        check("rst lo",    64'(loE),   64'd0);
        check("rst stall", 64'(stallMdD), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        runOp("mult",    4'd1, 32'hFFFFFFFE, 32'd3,        {32'hFFFFFFFF, 32'hFFFFFFFA}, 1'b0);
        runOp("multu",   4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 1'b0);
        runOp("div",     4'd3, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        runOp("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b0);
        runOp("divu /0", 4'd4, 32'd5,        32'd0,        {32'h00000000, 32'h80000000}, 1'b0);

        // mthi / mtlo / mfhi / mflo / out-of-range op
        mdOpE = 4'd7; rd1E = 32'h12345678; tick();
        mdOpE = 4'd8; rd1E = 32'h9ABCDEF0; tick();
        mdOpE = 4'd5; #1;
        check("mfhi", 64'(hiloOutE), 64'h12345678);
        mdOpE = 4'd6; #1;
        check("mflo", 64'(hiloOutE), 64'h9ABCDEF0);
        mdOpE = 4'd11; rd1E = 32'hDEADBEEF; #1;
        check("op11 out", 64'(hiloOutE), 64'd0);
        tick();
        check("op11 hilo", {hiE, loE}, {32'h12345678, 32'h9ABCDEF0});
        mHi = 32'h12345678; mLo = 32'h9ABCDEF0;
        mdOpE = 4'd0;

        // back-to-back MD with stall observation
        runOp("stall mult", 4'd1, 32'd7, 32'hFFFFFFFD, model(4'd1, 32'd7, 32'hFFFFFFFD), 1'b1);

        // randomised ops through the model
        for (int i = 0; i < 8; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            if (i == 2) rb = 32'd3;
            runOp("rand", rop, ra, rb, model(rop, ra, rb), (i % 2) == 1);
        end

        // reset during the 3rd busy cycle
        mdOpE = 4'd1; rd1E = 32'd1000; rd2E = 32'd1000;
        tick();
        mdOpE = 4'd0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busyE), 64'd0);
        check("midrst hilo", {hiE, loE}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("postrst busy", 64'(busyE), 64'd0);
        check("postrst hilo", {hiE, loE}, 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/md_unit_e.md
Name: md_unit_e

Overview:
- Multi-cycle multiply/divide unit in the execute stage.
- Consumes the operand and control outputs of the decode-to-execute pipeline register (rd1E, rd2E, decoded MD opcode).
- Owns the HI/LO architectural registers and serves mfhi/mflo reads into the execute result mux.
- Drives a stall request to the hazard logic while a multiply/divide is in flight, so that a later MD-class instruction is held in decode.

Parameters:
- MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mdOpE  input  4  op in execute: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none.
- rd1E  input  32  forwarded rs operand.
- rd2E  input  32  forwarded rt operand.
- mdInstD  input  1  instruction currently in decode is MD-class (op 1..8).
- busyE  output  1  registered; multiply/divide in progress.
- stallMdD  output  1  combinational stall request to the hazard unit.
- hiloOutE  output  32  combinational; HI for mfhi, LO for mflo, else 0.
- hiE  output  32  registered HI.
- loE  output  32  registered LO.

Behaviour:
- Reset: asynchronous; when rst_n is low, the following take effect immediately:
  - hiE = 0, loE = 0.
  - busyE = 0, internal counter = 0.
  - Pending-result registers = 0.
  - FSM in IDLE.
- FSM states:
  - IDLE, busyE = 0:
    - mdOpE 1..4 at a rising edge: latch the full 64-bit result, load counter with the op's cycle count, go to BUSY.
    - mdOpE 7 (mthi): next edge writes HI = rd1E.
    - mdOpE 8 (mtlo): next edge writes LO = rd1E.
  - BUSY, busyE = 1:
    - Counter decrements each edge.
    - On the edge where the counter goes 1 -> 0: commit the pending result to HI/LO and return to IDLE.
    - busyE is therefore high for exactly MULT_CYCLES/DIV_CYCLES cycles, starting the cycle after the start edge.
    - New HI/LO values are visible the cycle busyE falls.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div (signed): LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
    - 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
  - divu: unsigned quotient and remainder.
  - Divide by zero: op still runs the full DIV_CYCLES, but HI/LO stay unchanged at commit.
- Result is computed from the operands latched at the start edge; operand changes during BUSY have no effect.
- stallMdD = mdInstD & (busyE | mdOpE in 1..4). This holds the next MD instruction in decode until the cycle busyE falls.
- Ops 1..4, 7, 8 arriving while busyE = 1: ignored (hazard logic must prevent this; assertion in bench).
- mfhi/mflo while busyE = 1: hiloOutE returns the old register value. Only reachable if the stall is bypassed.
- Ops 9..15 and op 0: no state change, hiloOutE = 0.
- A bubble inserted by the pipeline-register clear arrives as mdOpE = 0 and has no effect.
- Reset mid-operation: the pending result is discarded and HI/LO read 0.

Test Plan:
- Reset, then mult rd1E = 0xFFFFFFFE (-2), rd2E = 3 -> busyE high for 5 cycles; then hiE = 0xFFFFFFFF, loE = 0xFFFFFFFA.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 5 busy cycles hiE = 0xFFFFFFFE, loE = 0x00000001.
- div 0xFFFFFFF9 (-7) / 2 -> busyE high for 10 cycles; loE = 0xFFFFFFFD, hiE = 0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> loE = 0x80000000, hiE = 0.
- divu 5 / 0 -> busyE high for 10 cycles; hiE/loE keep prior values.
- mthi 0x12345678, mtlo 0x9ABCDEF0, then mfhi -> hiloOutE = 0x12345678.
- Back-to-back MD: start mult with mdInstD = 1 -> stallMdD high on the start cycle and all 5 busy cycles, low the cycle busyE falls.
- Deassert rst_n in the 3rd busy cycle -> busyE, hiE, loE = 0 immediately; nothing is committed afterwards.
